// File: rtl/dmem_pkg.sv
// Shared constants, target encoding and FSM states for the data-memory access controller.
package dmem_pkg;

  localparam int ADDR_W     = 27;
  localparam int L1D_ADDR_W = 24;
  localparam int DATA_W     = 32;

  localparam logic [ADDR_W-1:0] L1D_END_DEFAULT  = 27'h1000000;
  localparam logic [ADDR_W-1:0] MU_START_DEFAULT = 27'h2000000;

  typedef enum logic {
    TGT_L1D = 1'b0,
    TGT_MU  = 1'b1
  } target_e;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_READY = 3'd1,
    ST_START      = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_DONE       = 3'd4,
    ST_FLUSH      = 3'd5
  } state_e;

endpackage

// File: rtl/dmem_range_decode.sv
// Classifies a CPU data access as slow (L1D or MU bus) or fast, and picks the bus target.
module dmem_range_decode
  import dmem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] L1D_END  = L1D_END_DEFAULT,
  parameter logic [ADDR_W-1:0] MU_START = MU_START_DEFAULT
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              re,
  input  logic              we,
  output target_e           target,
  output logic              slow,
  output logic              fast
);

  logic req;
  logic in_l1d;
  logic in_mu;

  assign req    = re | we;
  assign in_l1d = (addr < L1D_END);
  assign in_mu  = (addr >= MU_START);
  assign target = in_mu ? TGT_MU : TGT_L1D;
  assign slow   = req & (in_l1d | in_mu);
  assign fast   = req & ~(in_l1d | in_mu);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences slow CPU data accesses onto the L1D or MU bus, stalling the CPU until the
// transfer completes; a flushed transfer still waits for its done before going idle.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] L1D_END  = L1D_END_DEFAULT,
  parameter logic [ADDR_W-1:0] MU_START = MU_START_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  we,
  input  logic                  re,
  input  logic [DATA_W-1:0]     data,
  input  logic                  clear,
  input  logic                  hold,
  output logic [DATA_W-1:0]     q,
  output logic                  busy,
  output logic [L1D_ADDR_W-1:0] bus_l1d_addr,
  output logic [DATA_W-1:0]     bus_l1d_data,
  output logic                  bus_l1d_we,
  output logic                  bus_l1d_start,
  input  logic [DATA_W-1:0]     bus_l1d_q,
  input  logic                  bus_l1d_done,
  input  logic                  bus_l1d_ready,
  output logic [ADDR_W-1:0]     bus_mu_addr,
  output logic [DATA_W-1:0]     bus_mu_data,
  output logic                  bus_mu_we,
  output logic                  bus_mu_start,
  input  logic [DATA_W-1:0]     bus_mu_q,
  input  logic                  bus_mu_done,
  input  logic                  bus_mu_ready
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                we_q, we_d;
  target_e             target_q, target_d;
  logic [DATA_W-1:0]   q_q, q_d;

  target_e             dec_target;
  logic                dec_slow;
  logic                dec_fast;
  logic                accept;
  logic                sel_ready;
  logic                sel_done;
  logic [DATA_W-1:0]   sel_q;

  dmem_range_decode #(
    .L1D_END  (L1D_END),
    .MU_START (MU_START)
  ) u_decode (
    .addr   (addr),
    .re     (re),
    .we     (we),
    .target (dec_target),
    .slow   (dec_slow),
    .fast   (dec_fast)
  );

  // Handshakes from the bus that is not ours must never advance the FSM.
  assign sel_ready = (target_q == TGT_MU) ? bus_mu_ready : bus_l1d_ready;
  assign sel_done  = (target_q == TGT_MU) ? bus_mu_done  : bus_l1d_done;
  assign sel_q     = (target_q == TGT_MU) ? bus_mu_q     : bus_l1d_q;

  assign accept = (state_q == ST_IDLE) && dec_slow && !dec_fast && !clear;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      target_q <= TGT_L1D;
      q_q      <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      target_q <= target_d;
      q_q      <= q_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (accept) state_d = ST_WAIT_READY;
      ST_WAIT_READY: begin
        if (clear)          state_d = ST_IDLE;
        else if (sel_ready) state_d = ST_START;
      end
      ST_START:      state_d = clear ? ST_FLUSH : ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (sel_done)   state_d = ST_DONE;
        else if (clear) state_d = ST_FLUSH;
      end
      ST_DONE:       if (!hold) state_d = ST_IDLE;
      ST_FLUSH:      if (sel_done) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = we_q;
    target_d = target_q;
    q_d      = q_q;
    if (accept) begin
      addr_d   = addr;
      data_d   = data;
      we_d     = we;
      target_d = dec_target;
    end
    // A flushed transfer's read data is dropped; only WAIT_DONE updates q.
    if ((state_q == ST_WAIT_DONE) && sel_done) begin
      q_d = sel_q;
    end
  end

  always_comb begin
    bus_l1d_start = (state_q == ST_START) && (target_q == TGT_L1D);
    bus_mu_start  = (state_q == ST_START) && (target_q == TGT_MU);
    busy          = (dec_slow && (state_q != ST_DONE)) || (state_q == ST_FLUSH);
  end

  assign q            = q_q;
  assign bus_l1d_addr = addr_q[L1D_ADDR_W-1:0];
  assign bus_l1d_data = data_q;
  assign bus_l1d_we   = we_q && (target_q == TGT_L1D);
  assign bus_mu_addr  = addr_q;
  assign bus_mu_data  = data_q;
  assign bus_mu_we    = we_q && (target_q == TGT_MU);

endmodule
